// File: rtl/dmem_write_buffer_pkg.sv
// Shared types and constants for the data-memory store buffer.
package dmem_write_buffer_pkg;

  localparam int unsigned WB_DEPTH_DEFAULT = 4;
  localparam int unsigned WB_AW            = 32;
  localparam int unsigned WB_DW            = 32;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_SEND = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  // Word-granular address compare; the byte offset bits never take part.
  function automatic logic word_match(input logic [WB_AW-1:0] a,
                                      input logic [WB_AW-1:0] b);
    return a[WB_AW-1:2] == b[WB_AW-1:2];
  endfunction

endpackage

// File: rtl/dmem_write_buffer_if.sv
// Data-memory bus seen by the store buffer: write handshake plus the
// combinational read port used when a load misses the buffer.
interface dmem_write_buffer_if
  import dmem_write_buffer_pkg::*;
#(
  parameter int unsigned AW = WB_AW,
  parameter int unsigned DW = WB_DW
) ();

  logic          bus_wvalid;
  logic [AW-1:0] bus_waddr;
  logic [DW-1:0] bus_wdata;
  logic          bus_wready;
  logic [AW-1:0] bus_raddr;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_wvalid, bus_waddr, bus_wdata, bus_raddr,
    input  bus_wready, bus_rdata
  );

  modport slave (
    input  bus_wvalid, bus_waddr, bus_wdata, bus_raddr,
    output bus_wready, bus_rdata
  );

endinterface

// File: rtl/dmem_write_buffer_fwd_match.sv
// Store-to-load forwarding matcher: scans the buffer from the youngest
// entry (tail-1) back to the head and returns the first word-address hit.
module wb_fwd_match
  import dmem_write_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH_DEFAULT,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  wb_entry_t        entries_i [DEPTH],
  input  logic [DEPTH-1:0] valid_i,
  input  logic [PW-1:0]    head_i,
  input  logic [PW-1:0]    tail_i,
  input  logic [WB_AW-1:0] addr_i,
  output logic             hit_o,
  output logic [WB_DW-1:0] data_o
);

  logic [PW-1:0] idx;
  logic          done;

  // Youngest-first priority search, stopping once the head has been examined.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    done   = 1'b0;
    idx    = tail_i;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = idx - PW'(1);
      if (!done && valid_i[idx] && word_match(entries_i[idx].addr, addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
        done   = 1'b1;
      end
      if (idx == head_i) begin
        done = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Store buffer between the M stage and data memory: FIFO of full-word
// stores drained over a valid/ready bus, store-to-load forwarding, full
// stall output and fence handshake.
// Optional: define DMEM_WB_COALESCE_EN to merge a store into the youngest
// entry when the word addresses match.
module dmem_write_buffer
  import dmem_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEFAULT,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned DW    = WB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_write_m,
  input  logic [AW-1:0] data_addr_m,
  input  logic [DW-1:0] write_data_m,
  output logic [DW-1:0] read_data_m,
  output logic          full,
  input  logic          fence_req,
  output logic          fence_done,
  output logic          overflow,
  dmem_write_buffer_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t        entry_q [DEPTH];
  wb_entry_t        new_entry;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  wb_state_t        state_q, state_d;
  logic             fence_pending_q, fence_pending_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, coalesce;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    rel;
  logic [WB_AW-1:0] query_addr;
  logic             fwd_hit;
  logic [WB_DW-1:0] fwd_data;
`ifdef DMEM_WB_COALESCE_EN
  logic [PW-1:0]    tail_prev;
`endif

  // Enqueue/dequeue bookkeeping, overflow and fence tracking.
  always_comb begin
    query_addr = WB_AW'(data_addr_m);
    new_entry  = '{addr: query_addr, data: WB_DW'(write_data_m)};
    full       = (count_q == CW'(DEPTH));
    // Pop is taken from the registered state so the handshake never loops
    // back through the bus outputs driven by the FSM process.
    pop        = (state_q == WB_SEND) && bus.bus_wready;
`ifdef DMEM_WB_COALESCE_EN
    tail_prev  = tail_q - PW'(1);
    // A lone entry already on the bus must not change under the master.
    coalesce   = mem_write_m && (count_q != '0)
                 && word_match(entry_q[tail_prev].addr, query_addr)
                 && !((count_q == CW'(1)) && (state_q == WB_SEND));
`else
    coalesce   = 1'b0;
`endif
    push       = mem_write_m && !coalesce && (!full || pop);
    head_d     = pop  ? head_q + PW'(1) : head_q;
    tail_d     = push ? tail_q + PW'(1) : tail_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
    overflow_d      = overflow_q | (mem_write_m && !coalesce && full && !pop);
    fence_done      = fence_pending_q && (count_q == '0);
    fence_pending_d = fence_done ? 1'b0 : (fence_pending_q | fence_req);
  end

  // Occupancy mask: slot i is live when its distance from head is below count.
  always_comb begin
    valid = '0;
    rel   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel      = PW'(i) - head_q;
      valid[i] = ({1'b0, rel} < count_q);
    end
  end

  // Drain FSM next state and bus write outputs.
  always_comb begin
    state_d        = state_q;
    bus.bus_wvalid = 1'b0;
    bus.bus_waddr  = AW'(entry_q[head_q].addr);
    bus.bus_wdata  = DW'(entry_q[head_q].data);
    case (state_q)
      WB_IDLE: begin
        if (count_q != '0) begin
          state_d = WB_SEND;
        end
      end
      WB_SEND: begin
        bus.bus_wvalid = 1'b1;
        if (pop && (count_d == '0)) begin
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= WB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointer, count, fence and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      fence_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      fence_pending_q <= fence_pending_d;
      overflow_q      <= overflow_d;
    end
  end

  // Entry storage; contents are qualified by the occupancy mask, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_q[tail_q] <= new_entry;
    end
`ifdef DMEM_WB_COALESCE_EN
    else if (coalesce) begin
      entry_q[tail_prev].data <= new_entry.data;
    end
`endif
  end

  wb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd_match (
    .entries_i (entry_q),
    .valid_i   (valid),
    .head_i    (head_q),
    .tail_i    (tail_q),
    .addr_i    (query_addr),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

  // Load return path and remaining outputs.
  always_comb begin
    bus.bus_raddr = data_addr_m;
    read_data_m   = fwd_hit ? DW'(fwd_data) : bus.bus_rdata;
    overflow      = overflow_q;
  end

endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Store buffer directly downstream of the core's memory stage.
- Accepts the M-stage store stream (mem_write, data_addr_m, write_data_m) into a small FIFO and drains it to the data-memory bus through a valid/ready handshake.
- Serves M-stage loads with store-to-load forwarding, falling back to the bus read port.
- Exposes full (a stall request for the hazard unit) and a fence handshake.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- AW, 32, address width.
- DW, 32, data width; stores are full words.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-low.
- mem_write_m  in  1  store request from M stage.
- data_addr_m  in  AW  M-stage byte address for loads and stores.
- write_data_m  in  DW  store data.
- read_data_m  out  DW  load data returned to M stage.
- full  out  1  buffer cannot accept a new entry; the hazard unit stalls on it.
- fence_req  in  1  single-cycle pulse: request drain of all entries.
- fence_done  out  1  single-cycle pulse: fence complete.
- overflow  out  1  sticky error: a store was dropped.
- bus_wvalid  out  1  write request to memory.
- bus_waddr  out  AW  write address (head entry).
- bus_wdata  out  DW  write data (head entry).
- bus_wready  in  1  memory accepts the write.
- bus_raddr  out  AW  read address; equals data_addr_m.
- bus_rdata  in  DW  combinational read data from memory.

Behaviour:
- Reset (rst==0 at a posedge):
  - Pointers, count, state, fence_pending, fence_done, overflow and bus_wvalid all go to 0; full=0; state IDLE.
  - A drain in flight is abandoned and its entries are lost; memory is reset alongside.
- Storage:
  - Circular array of {addr, data} entries; head/tail pointers of log2(DEPTH) bits; count of log2(DEPTH)+1 bits.
  - full = (count==DEPTH), registered-derived, with no combinational path from the inputs.
- Drain FSM:
  - IDLE: bus_wvalid=0. Go to SEND when count!=0.
  - SEND: bus_wvalid=1; bus_waddr/bus_wdata driven from the head entry and held stable until bus_wready.
  - On a handshake (wvalid&&wready): pop the head. Return to IDLE only if the post-pop count is 0, else stay in SEND.
  - Throughput: one pop per cycle.
- Enqueue:
  - accept = mem_write_m && (!full || pop this cycle).
  - A simultaneous push and pop keeps count unchanged.
  - mem_write_m while full with no pop: the store is dropped and overflow sets, remaining set until reset.
  - Write latency to the bus is at least 1 cycle: an entry pushed in cycle N can appear on bus_wvalid in cycle N+1 at the earliest.
- Forwarding (combinational):
  - Compare data_addr_m[AW-1:2] against all valid entries, including the head being presented.
  - The youngest match wins; if none matches, read_data_m = bus_rdata.
  - The store being pushed in the same cycle is excluded.
  - read_data_m is don't-care when mem_write_m=1.
- Fence:
  - fence_req sets fence_pending.
  - fence_done pulses for 1 cycle in the first cycle with fence_pending && count==0, which clears fence_pending.
  - A fence_req with the buffer already empty gives fence_done in the next cycle.
  - Stores continue to be accepted during a fence and extend it.
  - A fence_req while already pending is absorbed.
- Address alignment: addr[1:0] is stored but ignored for matching.

Optional Feature:
- Macro: DMEM_WB_COALESCE_EN.
- Defined:
  - A store whose word address matches the tail (youngest) entry overwrites that entry's data in place; count is unchanged and overflow is not set, even when full.
  - Exception: if the tail is also the head and bus_wvalid=1, a normal enqueue is performed, so that bus data stays stable.
- Undefined: every accepted store allocates a new entry.

Decomposition:
- Shared package types:
  - wb_state_t enum {WB_IDLE, WB_SEND}.
  - wb_entry_t packed struct {addr, data}.
  - Constant WB_DEPTH_DEFAULT=4.
- Sub-module wb_fwd_match: a combinational youngest-first priority matcher over DEPTH entries, given valid mask, head, tail and query address; outputs hit and data.

Test Plan:
- Reset with stores in flight → all outputs 0 the next cycle; bus_wvalid=0 even though entries had been queued.
- Store 0x100=0xAAAA_0001 with bus_wready=0, then load 0x100 → read_data_m=0xAAAA_0001 (bus_rdata=0xDEAD_BEEF is ignored). Then bus_wready=1 → one handshake with waddr=0x100, and the entry pops.
- Stores 0x200=1 then 0x200=2 (coalescing disabled), load 0x202 → read_data_m=2; two bus writes in order 1 then 2.
- Five stores with bus_wready=0, DEPTH=4:
  - full=1 after the 4th store.
  - The 5th store is dropped and overflow=1.
  - With wready=1 thereafter, exactly 4 writes occur, FIFO-ordered.
- Full buffer with wready=1 and a store in the same cycle → push and pop together; count stays 4; no overflow.
- fence_req with 2 entries queued and wready=1 → fence_done pulses exactly once, the cycle after the 2nd handshake. A fence_req on an empty buffer → fence_done the next cycle.
